// File: rtl/uart_defs_pkg.sv
// Shared UART line definitions: default clock/baud and the clocks-per-bit
// derivation, used by both the receiver and the transmitter.
package uart_defs_pkg;

  localparam int unsigned DEF_CLK_HZ = 50_000_000;
  localparam int unsigned DEF_BAUD   = 115_200;

  // Integer clocks per bit; truncates, so the bit period is slightly short.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous input pins.
// The reset value is a parameter so idle-high lines do not glitch out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give metastability time to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples each bit at its midpoint (timed from the
// start-bit falling edge), assembles bytes LSB-first and hands them over
// through a single valid/ready holding register. Framing errors and
// overruns are reported as single-cycle pulses.
module uart_rx
  import uart_defs_pkg::*;
#(
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned BAUD         = DEF_BAUD,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic             rx_s;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             busy_q;
  logic             cnt_last;
  logic             deliver_d;
  logic             take_d;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  // Next shift value (LSB arrives first), end-of-bit tick and handshake terms.
  always_comb begin
    shift_d   = {rx_s, shift_q[7:1]};
    cnt_last  = (cnt_q == CNT_LAST);
    deliver_d = (state_q == S_STOP) && cnt_last && rx_s;
    take_d    = valid_q && ready;
  end

  // Receive FSM, bit timing, shift register and holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= S_DATA;
              idx_q   <= 3'd0;
            end else begin
              // Start bit did not survive to its midpoint: treat as noise.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              // Low stop bit: drop the byte and wait out the low line.
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_BREAK: begin
          cnt_q <= '0;
          if (rx_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // A simultaneous take frees the register, so a delivery then still lands.
      if (deliver_d) begin
        if (!valid_q || ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (take_d) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
